// File: rtl/pipe_div_unit.sv
// Multi-cycle restoring divider for the EXE stage: 32 iterations, signed/unsigned,
// with pipeline stall, flush abort and registered quotient/remainder.
module pipe_div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_ena,
   input  logic        div_sign,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        flush,
   output logic [31:0] q,
   output logic [31:0] r,
   output logic        busy,
   output logic        done,
   output logic        stall
);

   // Handshake: div_ena is a level request taken only in IDLE when flush=0;
   // stall holds the pipeline from that cycle through the last CALC cycle;
   // done pulses for exactly one cycle with q/r valid while stall is low.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [32:0] dvs_q, dvs_d;
   logic        signed_q, signed_d;
   logic        dnd_neg_q, dnd_neg_d;
   logic        dvs_neg_q, dvs_neg_d;
   logic        dvs_zero_q, dvs_zero_d;
   logic [31:0] q_q, q_d;
   logic [31:0] r_q, r_d;

   logic [31:0] dnd_mag;
   logic [31:0] dvs_mag;
   logic [32:0] step_shift;
   logic        step_ok;
   logic [31:0] step_diff;
   logic [31:0] step_rem;
   logic [31:0] step_quo;
   logic        neg_quo;
   logic [31:0] q_fin;
   logic [31:0] r_fin;

   // Magnitudes only in signed mode; 0x80000000 keeps its unsigned value.
   always_comb begin
      dnd_mag = dividend;
      dvs_mag = divisor;
      if (div_sign && dividend[31]) begin
         dnd_mag = -dividend;
      end
      if (div_sign && divisor[31]) begin
         dvs_mag = -divisor;
      end
   end

   // One restoring step: the compare uses the full 33-bit shifted remainder,
   // and the difference only matters when it fits, so 32 bits suffice there.
   always_comb begin
      step_shift = {rem_q, quo_q[31]};
      step_ok    = (step_shift >= dvs_q);
      step_diff  = step_shift[31:0] - dvs_q[31:0];
      step_rem   = step_ok ? step_diff : step_shift[31:0];
      step_quo   = {quo_q[30:0], step_ok};
   end

   // A zero divisor yields all-ones / dividend with no quotient negation.
   always_comb begin
      neg_quo = signed_q && (dnd_neg_q ^ dvs_neg_q) && !dvs_zero_q;
      q_fin   = neg_quo ? -step_quo : step_quo;
      r_fin   = (signed_q && dnd_neg_q) ? -step_rem : step_rem;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvs_d      = dvs_q;
      signed_d   = signed_q;
      dnd_neg_d  = dnd_neg_q;
      dvs_neg_d  = dvs_neg_q;
      dvs_zero_d = dvs_zero_q;
      q_d        = q_q;
      r_d        = r_q;
      case (state_q)
         S_IDLE: begin
            if (div_ena && !flush) begin
               state_d    = S_CALC;
               cnt_d      = 5'd31;
               rem_d      = 32'd0;
               quo_d      = dnd_mag;
               dvs_d      = {1'b0, dvs_mag};
               signed_d   = div_sign;
               dnd_neg_d  = dividend[31];
               dvs_neg_d  = divisor[31];
               dvs_zero_d = (divisor == 32'd0);
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q - 5'd1;
               if (cnt_q == 5'd0) begin
                  state_d = S_DONE;
                  q_d     = q_fin;
                  r_d     = r_fin;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 5'd0;
         rem_q      <= 32'd0;
         quo_q      <= 32'd0;
         dvs_q      <= 33'd0;
         signed_q   <= 1'b0;
         dnd_neg_q  <= 1'b0;
         dvs_neg_q  <= 1'b0;
         dvs_zero_q <= 1'b0;
         q_q        <= 32'd0;
         r_q        <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         signed_q   <= signed_d;
         dnd_neg_q  <= dnd_neg_d;
         dvs_neg_q  <= dvs_neg_d;
         dvs_zero_q <= dvs_zero_d;
         q_q        <= q_d;
         r_q        <= r_d;
      end
   end

   assign q     = q_q;
   assign r     = r_q;
   assign busy  = (state_q == S_CALC);
   assign done  = (state_q == S_DONE);
   assign stall = ((state_q == S_IDLE) && div_ena && !flush) || (state_q == S_CALC);

endmodule

// File: tb/tb_pipe_div_unit.sv
// Directed and randomized checks of pipe_div_unit against an arithmetic
// reference model (plain / and % on the operands).
module tb_pipe_div_unit;

   logic        clk;
   logic        rst;
   logic        div_ena;
   logic        div_sign;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        flush;
   logic [31:0] q;
   logic [31:0] r;
   logic        busy;
   logic        done;
   logic        stall;

   int checks;
   int failures;
   logic [31:0] last_q;
   logic [31:0] last_r;

   pipe_div_unit dut (
      .clk      (clk),
      .rst      (rst),
      .div_ena  (div_ena),
      .div_sign (div_sign),
      .dividend (dividend),
      .divisor  (divisor),
      .flush    (flush),
      .q        (q),
      .r        (r),
      .busy     (busy),
      .done     (done),
      .stall    (stall)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: truncating division, remainder follows dividend sign;
   // divide-by-zero gives all ones and the raw dividend.
   task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] eq, output logic [31:0] er);
      longint sa;
      longint sb;
      if (b == 32'd0) begin
         eq = 32'hFFFF_FFFF;
         er = a;
      end else if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         eq = 32'(sa / sb);
         er = 32'(sa % sb);
      end else begin
         eq = a / b;
         er = a % b;
      end
   endtask

   // driver: one full division from IDLE with latency / stall / result checks
   task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input bit noise, input bit flush_done);
      int lat;
      int stall_cnt;
      int busy_cnt;
      div_sign = sgn;
      dividend = a;
      divisor  = b;
      div_ena  = 1'b1;
      flush    = 1'b0;
      #1;
      stall_cnt = (stall === 1'b1) ? 1 : 0;
      busy_cnt  = 0;
      lat       = 0;
      tick();
      div_ena = 1'b0;
      while (done !== 1'b1 && lat < 40) begin
         if (stall === 1'b1) stall_cnt++;
         if (busy === 1'b1) busy_cnt++;
         if (noise) begin
            div_ena  = 1'($urandom_range(0, 1));
            div_sign = 1'($urandom_range(0, 1));
            dividend = $urandom;
            divisor  = $urandom;
         end
         tick();
         lat++;
      end
      div_ena = 1'b0;
      flush   = flush_done;
      #1;
      chk({tag, "_latency"}, 32'(lat), 32'd32);
      chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'd33);
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd32);
      chk({tag, "_stall_in_done"}, {31'd0, stall}, 32'd0);
      chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
      chk({tag, "_q"}, q, eq);
      chk({tag, "_r"}, r, er);
      tick();
      flush = 1'b0;
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, "_q_hold"}, q, eq);
      chk({tag, "_r_hold"}, r, er);
      last_q = eq;
      last_r = er;
   endtask

   initial begin
      logic [31:0] eq;
      logic [31:0] er;
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      int          lat;
      int          done_seen;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      div_ena  = 1'b0;
      div_sign = 1'b0;
      dividend = 32'd0;
      divisor  = 32'd0;
      flush    = 1'b0;
      last_q   = 32'd0;
      last_r   = 32'd0;

      // reset state
      tick();
      tick();
      chk("rst_q", q, 32'd0);
      chk("rst_r", r, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_stall_idle", {31'd0, stall}, 32'd0);
      div_ena = 1'b1;
      #1;
      chk("rst_stall_req", {31'd0, stall}, 32'd1);
      div_ena = 1'b0;
      rst = 1'b0;

      // directed cases with hand-derived results
      do_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
      do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
      do_div("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);
      do_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
      do_div("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0);
      do_div("s_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 1'b1);
      do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b1, 1'b0);

      // flush together with a request in IDLE must not start
      div_ena  = 1'b1;
      flush    = 1'b1;
      dividend = 32'd50;
      divisor  = 32'd5;
      #1;
      chk("idle_flush_stall", {31'd0, stall}, 32'd0);
      tick();
      div_ena = 1'b0;
      flush   = 1'b0;
      chk("idle_flush_busy", {31'd0, busy}, 32'd0);

      // flush in the 10th CALC cycle
      div_sign = 1'b0;
      dividend = 32'd1000;
      divisor  = 32'd3;
      div_ena  = 1'b1;
      tick();
      div_ena = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      chk("flush_busy_before", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_stall", {31'd0, stall}, 32'd0);
      chk("flush_q", q, last_q);
      chk("flush_r", r, last_r);
      done_seen = 0;
      for (int i = 0; i < 36; i++) begin
         if (done === 1'b1) done_seen++;
         tick();
      end
      chk("flush_no_done", 32'(done_seen), 32'd0);

      // reset in the 20th CALC cycle, then 9 / 3 right after release
      dividend = 32'd77;
      divisor  = 32'd5;
      div_ena  = 1'b1;
      tick();
      div_ena = 1'b0;
      for (int i = 0; i < 19; i++) tick();
      rst = 1'b1;
      #1;
      chk("midrst_q", q, 32'd0);
      chk("midrst_r", r, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_stall", {31'd0, stall}, 32'd0);
      tick();
      rst = 1'b0;
      do_div("after_rst_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);

      // back-to-back with div_ena held through DONE
      div_sign = 1'b0;
      dividend = 32'd200;
      divisor  = 32'd9;
      div_ena  = 1'b1;
      tick();
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      chk("b2b_first_latency", 32'(lat), 32'd32);
      chk("b2b_first_q", q, 32'd22);
      chk("b2b_first_r", r, 32'd2);
      chk("b2b_done_stall", {31'd0, stall}, 32'd0);
      dividend = 32'd50;
      divisor  = 32'd6;
      tick();
      chk("b2b_idle_stall", {31'd0, stall}, 32'd1);
      chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
      tick();
      div_ena = 1'b0;
      chk("b2b_second_busy", {31'd0, busy}, 32'd1);
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      chk("b2b_second_latency", 32'(lat), 32'd32);
      chk("b2b_second_q", q, 32'd8);
      chk("b2b_second_r", r, 32'd2);
      tick();

      // randomized operands against the reference model
      for (int i = 0; i < 24; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         b   = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = -32'($urandom_range(1, 15));
            3: b = 32'hFFFF_FFFF;
            4: a = 32'h8000_0000;
            default: a = 32'($urandom_range(0, 1000));
         endcase
         ref_div(sgn, a, b, eq, er);
         do_div("rand", sgn, a, b, eq, er, (i % 2) == 1, (i % 5) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
